// File: rtl/gray_decoder.sv
// gray_decoder: registered Gray-to-binary decoder with step checking.
// Samples GrayIn on En, converts it to binary, and checks that consecutive
// samples differ by a legal step (repeat or +1, and -1 when the down
// direction is enabled). Illegal steps pulse StepErr, bump a saturating
// error counter and resynchronise the reference to the new value.
// Optional feature macro: GRAY_DECODER_DOWN_EN (accept -1 steps, drive Dir).
module gray_decoder #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [WIDTH-1:0] Binary,
  output logic             Valid,
  output logic             StepErr,
  output logic [7:0]       ErrCount,
  output logic             Overflow,
  output logic             Dir
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [7:0]       ERR_MAX  = 8'd255;

  // MSB passes through; each lower bit is the XOR of the bit above and g[i].
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Saturating increment so the counter never wraps back to a small value.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == ERR_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic             valid_q, valid_d;
  logic             steperr_q, steperr_d;
  logic [7:0]       errcnt_q, errcnt_d;
  logic             ovf_q, ovf_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] sample_bin;
  logic [WIDTH-1:0] delta;

  assign sample_bin = gray_to_bin(GrayIn);
  // Modular difference: natural wrap of WIDTH-bit subtraction.
  assign delta      = sample_bin - binary_q;

  // Next-state and next-output logic; everything holds unless sampled.
  always_comb begin
    state_d   = state_q;
    binary_d  = binary_q;
    valid_d   = valid_q;
    steperr_d = 1'b0;
    errcnt_d  = errcnt_q;
    ovf_d     = ovf_q;
    dir_d     = dir_q;
    if (En) begin
      case (state_q)
        ST_EMPTY: begin
          // First sample after reset only establishes the reference.
          binary_d = sample_bin;
          valid_d  = 1'b1;
          state_d  = ST_TRACK;
        end
        ST_TRACK: begin
          if (delta == ZERO) begin
            binary_d = binary_q;
          end else if (delta == ONE) begin
            binary_d = sample_bin;
            dir_d    = 1'b0;
            if (binary_q == ALL_ONES) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
`ifdef GRAY_DECODER_DOWN_EN
          end else if (delta == ALL_ONES) begin
            binary_d = sample_bin;
            dir_d    = 1'b1;
            if (binary_q == ZERO) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
`endif
          end else begin
            // Illegal jump: flag it, count it, and follow the new value.
            binary_d  = sample_bin;
            steperr_d = 1'b1;
            errcnt_d  = sat_inc(errcnt_q);
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_EMPTY;
      binary_q  <= ZERO;
      valid_q   <= 1'b0;
      steperr_q <= 1'b0;
      errcnt_q  <= 8'd0;
      ovf_q     <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      binary_q  <= binary_d;
      valid_q   <= valid_d;
      steperr_q <= steperr_d;
      errcnt_q  <= errcnt_d;
      ovf_q     <= ovf_d;
      dir_q     <= dir_d;
    end
  end

  assign Binary   = binary_q;
  assign Valid    = valid_q;
  assign StepErr  = steperr_q;
  assign ErrCount = errcnt_q;
  assign Overflow = ovf_q;
  assign Dir      = dir_q;

endmodule
